// File: rtl/rr_grant_sched_if.sv
// rtl/rr_grant_sched_if.sv - request/grant bundle between requesters and the round-robin scheduler
interface rr_grant_sched_if #(
    parameter int N   = 8,
    parameter int IDW = 3
);
    logic [N-1:0]   req;
    logic [N-1:0]   grant;
    logic           grant_valid;
    logic [IDW-1:0] grant_id;
    logic           preempt;

    modport master (
        output req,
        input  grant,
        input  grant_valid,
        input  grant_id,
        input  preempt
    );

    modport slave (
        input  req,
        output grant,
        output grant_valid,
        output grant_id,
        output preempt
    );
endinterface

// File: rtl/rr_grant_sched.sv
// rtl/rr_grant_sched.sv - registered round-robin arbiter with hold-until-release grants
// Optional owner timeout/preemption is built when GRANT_TIMEOUT_EN is defined.
module rr_grant_sched #(
    parameter int N        = 8,
    parameter int IDW      = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    rr_grant_sched_if.slave   arb
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [N-1:0] ONE_HOT_0 = {{(N-1){1'b0}}, 1'b1};

    if (N < 2 || N > 16 || IDW != $clog2(N) || MAX_HOLD < 2) begin : g_bad_cfg
        $error("rr_grant_sched: illegal N/IDW/MAX_HOLD combination");
    end

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [N-1:0]   grant_q, grant_d;
    logic [IDW-1:0] id_q, id_d;
    logic           preempt_q, preempt_d;

    // Result is {found, index}; the scan starts at p and wraps past N-1 to 0.
    function automatic logic [IDW:0] pick(input logic [N-1:0] r, input logic [IDW-1:0] p);
        logic [IDW:0] res;
        int           idx;
        res = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = int'(p) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (r[idx[IDW-1:0]]) begin
                res = {1'b1, idx[IDW-1:0]};
            end
        end
        return res;
    endfunction

    logic [IDW-1:0] next_ptr;
    logic [IDW:0]   pick_idle;
    logic [IDW:0]   pick_rel;

    assign next_ptr  = (id_q == IDW'(N - 1)) ? '0 : id_q + 1'b1;
    assign pick_idle = pick(arb.req, ptr_q);
    assign pick_rel  = pick(arb.req, next_ptr);

`ifdef GRANT_TIMEOUT_EN
    localparam int HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;

    logic [HW-1:0] hold_q, hold_d;
    logic [IDW:0]  pick_to;

    // The expiring owner is masked so the pick prefers anyone else.
    assign pick_to = pick(arb.req & ~grant_q, next_ptr);
`endif

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        id_d      = id_q;
        preempt_d = 1'b0;
`ifdef GRANT_TIMEOUT_EN
        hold_d    = hold_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_idle[IDW]) begin
                    state_d = BUSY;
                    id_d    = pick_idle[IDW-1:0];
                    grant_d = ONE_HOT_0 << pick_idle[IDW-1:0];
`ifdef GRANT_TIMEOUT_EN
                    hold_d  = '0;
`endif
                end
            end
            BUSY: begin
                if (!arb.req[id_q]) begin
                    // Release wins over a coincident timeout: no preempt pulse.
                    ptr_d = next_ptr;
                    if (pick_rel[IDW]) begin
                        id_d    = pick_rel[IDW-1:0];
                        grant_d = ONE_HOT_0 << pick_rel[IDW-1:0];
                    end else begin
                        state_d = IDLE;
                        id_d    = '0;
                        grant_d = '0;
                    end
`ifdef GRANT_TIMEOUT_EN
                    hold_d = '0;
                end else if (hold_q == HW'(MAX_HOLD - 1)) begin
                    preempt_d = 1'b1;
                    ptr_d     = next_ptr;
                    hold_d    = '0;
                    if (pick_to[IDW]) begin
                        id_d    = pick_to[IDW-1:0];
                        grant_d = ONE_HOT_0 << pick_to[IDW-1:0];
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                id_d    = '0;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            grant_q   <= '0;
            id_q      <= '0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            id_q      <= id_d;
            preempt_q <= preempt_d;
        end
    end

`ifdef GRANT_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`endif

    assign arb.grant       = grant_q;
    assign arb.grant_valid = (state_q == BUSY);
    assign arb.grant_id    = id_q;
    assign arb.preempt     = preempt_q;

    a_grant_consistent: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(grant_q) && ((state_q == BUSY) == (grant_q != '0)));

endmodule

// File: tb/tb_rr_grant_sched.sv
// tb/tb_rr_grant_sched.sv - scoreboard bench for rr_grant_sched (N=8, MAX_HOLD=4)
module tb_rr_grant_sched;

    localparam int N    = 8;
    localparam int IDW  = 3;
    localparam int MAXH = 4;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   failures;

    rr_grant_sched_if #(.N(N), .IDW(IDW)) bus ();

    rr_grant_sched #(.N(N), .IDW(IDW), .MAX_HOLD(MAXH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .arb   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int             due;
        logic [N-1:0]   grant;
        logic           valid;
        logic [IDW-1:0] id;
        logic           pre;
    } exp_t;

    exp_t q[$];

    // Reference model state: owner index (-1 = none), priority start, cycles held.
    int m_owner;
    int m_ptr;
    int m_hold;

    function automatic int mpick(input logic [N-1:0] r, input int from, input int skip);
        int j;
        for (int i = 0; i < N; i++) begin
            j = (from + i) % N;
            if (r[j] && j != skip) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_hold  = 0;
    endtask

    task automatic model_step(input logic [N-1:0] r, output logic pre);
        int k;
        pre = 1'b0;
        if (m_owner < 0) begin
            m_owner = mpick(r, m_ptr, -1);
            m_hold  = 0;
        end else if (!r[m_owner]) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = mpick(r, m_ptr, -1);
            m_hold  = 0;
        end
`ifdef GRANT_TIMEOUT_EN
        else if (m_hold == MAXH - 1) begin
            pre   = 1'b1;
            m_ptr = (m_owner + 1) % N;
            k     = mpick(r, m_ptr, m_owner);
            if (k >= 0) m_owner = k;
            m_hold = 0;
        end else begin
            m_hold++;
        end
`endif
        k = 0;
    endtask

    task automatic push_expect(input logic pre);
        exp_t e;
        e.due   = cyc + 1;
        e.valid = (m_owner >= 0);
        e.grant = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        e.id    = (m_owner >= 0) ? IDW'(m_owner) : '0;
        e.pre   = pre;
        q.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // One call = exactly one DUT clock edge of stimulus.
    task automatic step(input logic [N-1:0] r);
        logic pre;
        @(posedge clk);
        #1;
        bus.req = r;
        model_step(r, pre);
        push_expect(pre);
    endtask

    task automatic async_reset(input logic [N-1:0] new_req);
        logic pre;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("areset_grant", 32'(bus.grant), 32'h0);
        chk("areset_valid", 32'(bus.grant_valid), 32'h0);
        chk("areset_id", 32'(bus.grant_id), 32'h0);
        chk("areset_preempt", 32'(bus.preempt), 32'h0);
        #1;
        rst_n = 1'b1;
        while (q.size() > 0 && q[q.size()-1].due > cyc) begin
            void'(q.pop_back());
        end
        model_reset();
        bus.req = new_req;
        model_step(new_req, pre);
        push_expect(pre);
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            checks++;
            if (e.due < cyc) begin
                failures++;
                $display("FAIL stale_expect: due cycle %0d seen at cycle %0d", e.due, cyc);
            end else if ({bus.grant, bus.grant_valid, bus.grant_id, bus.preempt} !==
                         {e.grant, e.valid, e.id, e.pre}) begin
                failures++;
                $display("FAIL grant_cycle%0d: got grant=%h valid=%b id=%0d preempt=%b, expected grant=%h valid=%b id=%0d preempt=%b",
                         cyc, bus.grant, bus.grant_valid, bus.grant_id, bus.preempt,
                         e.grant, e.valid, e.id, e.pre);
            end
        end
    end

    initial begin
        logic [N-1:0] r;
        logic         pre;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus.req  = '0;
        model_reset();

        repeat (2) @(negedge clk);
        chk("reset_grant", 32'(bus.grant), 32'h0);
        chk("reset_valid", 32'(bus.grant_valid), 32'h0);
        chk("reset_id", 32'(bus.grant_id), 32'h0);
        chk("reset_preempt", 32'(bus.preempt), 32'h0);

        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_step(bus.req, pre);
        push_expect(pre);

        // Single request, one-cycle latency
        step(8'h00);
        step(8'h04);
        repeat (3) step(8'h04);
        step(8'h00);

        // Rotation with every owner dropping for one cycle
        async_reset(8'hFF);
        step(8'hFF);
        for (int i = 0; i < 9; i++) begin
            step(8'hFF & ~(N'(1) << m_owner));
            step(8'hFF);
        end
        step(8'h00);

        // Wrap and skip: owner 6 releases with 7 clear, 0 and 1 pending
        async_reset(8'h40);
        step(8'h43);
        step(8'h43);
        step(8'h03);
        step(8'h03);
        step(8'h00);

        // Async reset mid-grant, then pick restarts from index 0
        step(8'h10);
        step(8'h10);
        step(8'h10);
        async_reset(8'h90);
        step(8'h90);
        step(8'h80);
        step(8'h80);
        step(8'h00);

        // Long holds: preempt rotation when enabled, indefinite hold otherwise
        repeat (20) step(8'h03);
        step(8'h00);
        repeat (12) step(8'h01);
        step(8'h00);
        repeat (100) step(8'h03);
        step(8'h00);

        // Randomized sticky requests
        r = '0;
        for (int i = 0; i < 400; i++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
            end
            step(r);
        end
        step(8'h00);
        step(8'h00);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
